// File: rtl/md_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package md_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } md_state_e;

    // MULT and DIV are the signed forms; both have op[0] clear.
    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Applies result signs to the magnitude accumulator: 2W product for multiply,
// or independent quotient/remainder negation for divide.
module md_sign_fix
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic               neg_quot_i,
    input  logic               neg_rem_i,
    input  logic               is_mult_i,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        prod = neg_quot_i ? -acc_i : acc_i;
        quot = neg_quot_i ? -acc_i[WIDTH-1:0] : acc_i[WIDTH-1:0];
        rem  = neg_rem_i ? -acc_i[2*WIDTH-1:WIDTH] : acc_i[2*WIDTH-1:WIDTH];
        if (is_mult_i) begin
            hi_o = prod[2*WIDTH-1:WIDTH];
            lo_o = prod[WIDTH-1:0];
        end else begin
            hi_o = rem;
            lo_o = quot;
        end
    end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes over WIDTH cycles, signs applied in a final fix-up cycle.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    md_state_e          state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               neg_quot_q, neg_quot_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               is_mult;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_diff;
    logic               rem_fits;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
        a_neg = md_is_signed(op) & a[WIDTH-1];
        b_neg = md_is_signed(op) & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    assign is_mult = ~op_q[1];

    // Multiply: acc = {product_hi, multiplier}; add into the upper half, then shift right.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Divide: acc = {rem, quot}; a borrow out of the trial subtract means no fit.
    always_comb begin
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        rem_diff = rem_sh - {1'b0, opnd_q};
        rem_fits = ~rem_diff[WIDTH];
        div_next = {rem_fits ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0],
                    acc_q[WIDTH-2:0], rem_fits};
    end

    md_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .acc_i      (acc_q),
        .neg_quot_i (neg_quot_q),
        .neg_rem_i  (neg_rem_q),
        .is_mult_i  (is_mult),
        .hi_o       (fix_hi),
        .lo_o       (fix_lo)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dz_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d       = op;
                    neg_quot_d = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    opnd_d     = op[1] ? b_mag : a_mag;
                    acc_d      = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
                    cnt_d      = '0;
                    if (op[1] && (b == '0)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = is_mult ? mul_next : div_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            op_q       <= MD_MULT;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            acc_q      <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dz_q       <= dz_d;
        end
    end

    assign busy     = (state_q == S_RUN) || (state_q == S_FIX);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit for the multicycle datapath; executes MULT, MULTU, DIV and DIVU.
- Sits downstream of the ALU operand selection. Consumes operand A (register A) and operand B (register B) latched by the control unit.
- Produces the HI/LO pair read by MFHI/MFLO.
- The control FSM pulses start, then waits in a stall state until done.

Parameters:
WIDTH, 32, operand width; hi/lo are WIDTH each; the internal accumulator is 2*WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request; sampled only in IDLE.
op  input  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
a  input  WIDTH  operand A (multiplicand / dividend).
b  input  WIDTH  operand B (multiplier / divisor).
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse; hi/lo are valid in the same cycle.
div_zero  output  1  pulses with done when DIV/DIVU had b==0.
hi  output  WIDTH  HI register (product upper half / remainder).
lo  output  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; iteration counter=0. Asserting reset mid-operation aborts the operation immediately; no partial result is written.
- States: IDLE, RUN, FIX, DONE.
- IDLE + start=1 at edge E0:
  - Latch op and sign flags.
  - For signed ops (MULT, DIV), latch |a| and |b| and compute neg_q = a[MSB]^b[MSB] and neg_r = a[MSB]. For unsigned ops, use raw values and clear both flags.
  - Load the accumulator, set count=0, go to RUN.
  - Exception: DIV/DIVU with b==0 goes directly to DONE with a zero flag set.
- IDLE, start=0: hold; done=0.
- RUN, multiply (shift-add on magnitudes): each edge, if acc[0] then acc[2W-1:W] += multiplicand with carry into bit 2W; then shift acc right by 1.
- RUN, divide (restoring on magnitudes): each edge, shift {rem,quot} left by 1; if rem >= divisor, then rem -= divisor and quot[0]=1.
- RUN exit: count increments each edge; after WIDTH edges (edges E1..E32), go to FIX.
- FIX (edge E33): apply signs and write hi/lo; go to DONE with done=1.
  - Multiply: 2W product negated if neg_q.
  - Divide: lo = quot, negated if neg_q; hi = rem, negated if neg_r.
- DONE: one cycle, then return to IDLE.
  - done is registered high for exactly one cycle after E33.
  - Latency: done is visible in the cycle after edge E33, i.e. 34 edges after start was sampled.
  - A divide-by-zero raises done and div_zero one cycle after E0; hi/lo keep their previous values.
- busy=1 in RUN and FIX; busy=0 in IDLE and DONE.
- start while busy, or in DONE: ignored; operands are not re-latched.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. This falls out of the unsigned magnitude path; it is not flagged.
- hi/lo change only at FIX and at reset. They hold across IDLE indefinitely.
- op, a and b may change freely after E0.

Decomposition:
- Shared package md_pkg holds:
  - op encodings MD_MULT=2'd0, MD_MULTU=2'd1, MD_DIV=2'd2, MD_DIVU=2'd3;
  - state encodings S_IDLE, S_RUN, S_FIX, S_DONE;
  - width constant MD_WIDTH=32.
- Sub-module md_sign_fix: combinational; takes magnitude results plus neg_q/neg_r/is_mult and returns signed hi/lo. It is reused at FIX only.
- All sequential logic stays in md_unit. The accumulator is shared between the multiply and divide paths.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001. done pulses exactly 34 edges after start; busy is high for 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7: hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). Then MULT a=0x80000000, b=0x80000000: hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2: lo=3, hi=1. DIVU a=0xFFFFFFF9, b=2: lo=0x7FFFFFFC, hi=1.
- DIV a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0, div_zero=0.
- Preload hi=0x12, lo=0x34 via a prior op, then DIV a=5, b=0: done and div_zero pulse one cycle after start; hi/lo stay 0x12/0x34.
- Start MULTU 3*4, re-pulse start with op=DIVU mid-RUN: ignored, result hi=0, lo=12. Restart, drop reset_n asynchronously at edge 10: busy, done, hi and lo go to 0 immediately. After release, a new op completes normally.
